led_matrix_driver: RTL and testbench

- Serial-loaded 8x8 LED matrix scan driver, the core of the TinyTapeout tile tt_um_mjbella_led_matrix_driver.
- An external host shifts a 64-bit frame in over a slow serial link (din/dclk) and commits it with a strobe.
- The block multiplexes the committed frame row by row onto 8 column drives and 8 active-low row drives.
- Tile pin mapping: ui_in[0]=din, ui_in[1]=dclk, ui_in[2]=strobe, uo_out=col, uio_out=row_n, uio_oe=8'hFF. The tile wrapper drives rst = ~rst_n.

---
 rtl/led_matrix_driver.sv | 99 +++++++++
 tb/tb_led_matrix_driver.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/led_matrix_driver.sv
// Serial-loaded 8x8 LED matrix scan driver: shifts a 64-bit frame in over
// din/dclk, commits it on strobe, and multiplexes it row by row.
module led_matrix_driver #(
    parameter int SCAN_DIV    = 1024,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ena,
    input  logic       din,
    input  logic       dclk,
    input  logic       strobe,
    output logic [7:0] col,
    output logic [7:0] row_n,
    output logic [7:0] oe
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

    logic [SYNC_STAGES-1:0] r_din_s;
    logic [SYNC_STAGES-1:0] r_dclk_s;
    logic [SYNC_STAGES-1:0] r_stb_s;
    logic                   r_dclk_prev;
    logic                   r_stb_prev;
    logic [63:0]            r_sr;
    logic [63:0]            r_fb;
    logic [PW-1:0]          r_presc;
    logic [2:0]             r_row;
    logic [7:0]             r_col;
    logic [7:0]             r_row_n;

    logic       w_din;
    logic       w_dclk_rise;
    logic       w_stb_rise;
    logic [7:0] w_row_sel;

    assign w_din       = r_din_s[SYNC_STAGES-1];
    assign w_dclk_rise = r_dclk_s[SYNC_STAGES-1] & ~r_dclk_prev;
    assign w_stb_rise  = r_stb_s[SYNC_STAGES-1] & ~r_stb_prev;
    assign w_row_sel   = 8'b1 << r_row;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_din_s     <= '0;
            r_dclk_s    <= '0;
            r_stb_s     <= '0;
            r_dclk_prev <= 1'b0;
            r_stb_prev  <= 1'b0;
        end else begin
            r_din_s     <= {r_din_s[SYNC_STAGES-2:0], din};
            r_dclk_s    <= {r_dclk_s[SYNC_STAGES-2:0], dclk};
            r_stb_s     <= {r_stb_s[SYNC_STAGES-2:0], strobe};
            r_dclk_prev <= r_dclk_s[SYNC_STAGES-1];
            r_stb_prev  <= r_stb_s[SYNC_STAGES-1];
        end
    end

    // fb takes sr's pre-shift value when strobe and dclk pulse together
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sr <= '0;
            r_fb <= '0;
        end else begin
            if (w_dclk_rise) r_sr <= {r_sr[62:0], w_din};
            if (w_stb_rise)  r_fb <= r_sr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_presc <= '0;
            r_row   <= '0;
        end else if (r_presc == PRESC_MAX) begin
            r_presc <= '0;
            r_row   <= r_row + 3'd1;
        end else begin
            r_presc <= r_presc + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col   <= 8'h00;
            r_row_n <= 8'hFF;
        end else if (ena) begin
            r_col   <= r_fb[{r_row, 3'b000} +: 8];
            r_row_n <= ~w_row_sel;
        end else begin
            r_col   <= 8'h00;
            r_row_n <= 8'hFF;
        end
    end

    assign col   = r_col;
    assign row_n = r_row_n;
    assign oe    = 8'hFF;

endmodule

// File: tb/tb_led_matrix_driver.sv
// Scoreboard bench for led_matrix_driver: stimulus schedules expected
// row_n/col per clk cycle; a monitor pops and compares on those cycles.
module tb_led_matrix_driver;

    localparam int SD = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic       ena;
    logic       din;
    logic       dclk;
    logic       strobe;
    logic [7:0] col;
    logic [7:0] row_n;
    logic [7:0] oe;

    led_matrix_driver #(.SCAN_DIV(SD), .SYNC_STAGES(2)) dut (
        .clk    (clk),
        .rst    (rst),
        .ena    (ena),
        .din    (din),
        .dclk   (dclk),
        .strobe (strobe),
        .col    (col),
        .row_n  (row_n),
        .oe     (oe)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        int         k;
        string      nm;
        logic [7:0] rn;
        logic [7:0] c;
    } chk_t;

    chk_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   rel   = 0;

    always @(negedge clk) begin : mon
        chk_t e;
        while (q.size() > 0 && q[0].k <= cyc) begin
            e = q.pop_front();
            total++;
            if (e.k < cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d missed at %0d",
                         e.nm, e.k, cyc);
            end else if (row_n !== e.rn || col !== e.c || oe !== 8'hFF) begin
                bad++;
                $display("FAIL %s cyc=%0d: row_n=%h col=%h oe=%h, need row_n=%h col=%h oe=ff",
                         e.nm, cyc, row_n, col, oe, e.rn, e.c);
            end
        end
    end

    task automatic push(input int k, input string nm,
                        input logic [7:0] rn, input logic [7:0] c);
        chk_t e;
        e.k  = k;
        e.nm = nm;
        e.rn = rn;
        e.c  = c;
        q.push_back(e);
    endtask

    // Displayed row after edge k, counting from the first edge out of reset
    function automatic int row_at(input int k);
        return ((k - rel) / SD) % 8;
    endfunction

    task automatic push_row(input int k, input string nm, input logic [63:0] f);
        int r;
        logic [7:0] sel;
        r = row_at(k);
        sel = 8'd1 << r;
        push(k, nm, ~sel, f[8*r +: 8]);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic shift_bit(input logic b);
        din = b;
        wait_cyc(4);
        dclk = 1'b1;
        wait_cyc(4);
        dclk = 1'b0;
    endtask

    task automatic shift_frame(input logic [63:0] f);
        for (int i = 63; i >= 0; i--) shift_bit(f[i]);
    endtask

    task automatic pulse_strobe();
        wait_cyc(4);
        strobe = 1'b1;
        wait_cyc(4);
        strobe = 1'b0;
        wait_cyc(6);
    endtask

    // Checks both sides of 9 consecutive row boundaries (covers the 7->0 wrap)
    task automatic check_frame(input logic [63:0] f, input string nm);
        int st;
        int b;
        int last;
        st = cyc + 4;
        b = rel + ((st - rel + SD - 1) / SD) * SD;
        for (int j = 0; j < 9; j++) begin
            push_row(b + j*SD - 1, nm, f);
            push_row(b + j*SD, nm, f);
        end
        last = b + 8*SD;
        wait_cyc(last - cyc + 2);
    endtask

    task automatic do_reset(input string nm);
        rst = 1'b1;
        push(cyc + 1, nm, 8'hFF, 8'h00);
        push(cyc + 2, nm, 8'hFF, 8'h00);
        wait_cyc(2);
        rst = 1'b0;
        rel = cyc + 1;
        push(rel, {nm, "_rel"}, 8'hFE, 8'h00);
        push(rel + SD - 1, {nm, "_row0end"}, 8'hFE, 8'h00);
        push(rel + SD, {nm, "_row1"}, 8'hFD, 8'h00);
        wait_cyc(SD + 4);
    endtask

    localparam logic [63:0] F_DIAG = 64'h8040_2010_0804_0201;
    localparam logic [63:0] F_ONES = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] F_AA   = 64'hAAAA_AAAA_AAAA_AAAA;

    initial begin
        int c;
        rst    = 1'b1;
        ena    = 1'b1;
        din    = 1'b0;
        dclk   = 1'b0;
        strobe = 1'b0;

        do_reset("reset");

        shift_frame(F_DIAG);
        pulse_strobe();
        check_frame(F_DIAG, "diag");

        c = cyc;
        ena = 1'b0;
        push(c + 1, "ena_off", 8'hFF, 8'h00);
        push(c + 5, "ena_off_hold", 8'hFF, 8'h00);
        wait_cyc(10);
        ena = 1'b1;
        push_row(c + 11, "ena_on", F_DIAG);
        push_row(c + 11 + SD, "ena_on_next", F_DIAG);
        wait_cyc(SD + 4);

        shift_frame(F_ONES);
        wait_cyc(8);
        check_frame(F_DIAG, "no_strobe");
        pulse_strobe();
        check_frame(F_ONES, "ones");

        repeat (8) shift_bit(1'b1);
        shift_frame(64'h0);
        pulse_strobe();
        check_frame(64'h0, "overrun");
        repeat (8) shift_bit(1'b1);
        pulse_strobe();
        check_frame(64'hFF, "row0_ff");

        for (int i = 0; i < 30; i++) shift_bit(i[0]);
        do_reset("rst_mid");
        pulse_strobe();
        check_frame(64'h0, "rst_sr_clear");
        shift_frame(F_AA);
        pulse_strobe();
        check_frame(F_AA, "aa");

        for (int i = 0; i < 3000 && q.size() > 0; i++) wait_cyc(1);
        if (q.size() > 0) begin
            bad++;
            $display("FAIL drain: %0d checks pending, need 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
